// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows the EX/MEM/WB destinations, raises load-use and
// memory-wait stalls, and reports pending writes. HAZARD_SB_STATS_EN adds stall_cycles.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [1:0]  id_rs,
    input  logic [1:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [1:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    input  logic        mem_ready,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic [1:0]  ex_rd,
    output logic [1:0]  mem_rd,
    output logic [1:0]  wb_rd,
    output logic        ex_regwrite,
    output logic        mem_regwrite,
    output logic        wb_regwrite,
`ifdef HAZARD_SB_STATS_EN
    output logic [15:0] stall_cycles,
`endif
    output logic [3:0]  pend_mask
);

    typedef struct packed {
        logic       regwrite;
        logic [1:0] rd;
        logic       memread;
    } slot_t;

    localparam slot_t BUBBLE_SLOT = 4'b0000;

    slot_t ex_r;
    slot_t mem_r;
    slot_t wb_r;
    slot_t id_slot_s;
    logic  advance_s;
    logic  issue_s;
    logic  load_use_s;

    // One-hot destination of a slot, empty when the slot does not write
    function automatic logic [3:0] dest_onehot(input slot_t s);
        logic [3:0] m;
        m = 4'b0000;
        if (s.regwrite) begin
            m[s.rd] = 1'b1;
        end else begin
            m = 4'b0000;
        end
        return m;
    endfunction

    // Hazard detection; only a load sitting in EX can force a stall, later stages forward
    always_comb begin
        load_use_s = 1'b0;
        id_slot_s  = BUBBLE_SLOT;
        if (id_valid && ex_r.regwrite && ex_r.memread) begin
            load_use_s = (id_use_rs && (id_rs == ex_r.rd)) ||
                         (id_use_rt && (id_rt == ex_r.rd));
        end else begin
            load_use_s = 1'b0;
        end
        id_slot_s.regwrite = id_regwrite;
        id_slot_s.rd       = id_rd;
        id_slot_s.memread  = id_memread;
    end

    assign advance_s = mem_ready;
    assign stall_id  = load_use_s | ~mem_ready;
    assign issue_s   = id_valid & ~stall_id & ~flush;
    assign bubble_ex = advance_s & ~issue_s;

    // Slot pipeline: shift on advance; a frozen pipeline still lets flush squash EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r  <= BUBBLE_SLOT;
            mem_r <= BUBBLE_SLOT;
            wb_r  <= BUBBLE_SLOT;
        end else if (advance_s) begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= issue_s ? id_slot_s : BUBBLE_SLOT;
        end else if (flush) begin
            ex_r  <= BUBBLE_SLOT;
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end else begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end
    end

    assign ex_rd        = ex_r.rd;
    assign mem_rd       = mem_r.rd;
    assign wb_rd        = wb_r.rd;
    assign ex_regwrite  = ex_r.regwrite;
    assign mem_regwrite = mem_r.regwrite;
    assign wb_regwrite  = wb_r.regwrite;
    assign pend_mask    = dest_onehot(ex_r) | dest_onehot(mem_r) | dest_onehot(wb_r);

`ifdef HAZARD_SB_STATS_EN
    // Saturating count of cycles a real instruction spent stalled in ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'h0000;
        end else if (id_valid && stall_id && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'h0001;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard; stall counter checks need HAZARD_SB_STATS_EN.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [1:0]  id_rs;
    logic [1:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [1:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic        mem_ready;
    logic        stall_id;
    logic        bubble_ex;
    logic [1:0]  ex_rd;
    logic [1:0]  mem_rd;
    logic [1:0]  wb_rd;
    logic        ex_regwrite;
    logic        mem_regwrite;
    logic        wb_regwrite;
    logic [3:0]  pend_mask;
`ifdef HAZARD_SB_STATS_EN
    logic [15:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_valid(id_valid),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt),
        .id_rd(id_rd),
        .id_regwrite(id_regwrite),
        .id_memread(id_memread),
        .flush(flush),
        .mem_ready(mem_ready),
        .stall_id(stall_id),
        .bubble_ex(bubble_ex),
        .ex_rd(ex_rd),
        .mem_rd(mem_rd),
        .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite),
        .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite),
`ifdef HAZARD_SB_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .pend_mask(pend_mask)
    );

    // inputs | combinational outputs before the edge | slot outputs after the edge
    typedef struct {
        logic       v;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       urs;
        logic       urt;
        logic [1:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       mrdy;
        logic       e_stall;
        logic       e_bubble;
        logic [1:0] e_ex_rd;
        logic       e_ex_rw;
        logic [1:0] e_mem_rd;
        logic       e_mem_rw;
        logic [1:0] e_wb_rd;
        logic       e_wb_rw;
        logic [3:0] e_pend;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                         input logic urs, input logic urt, input logic [1:0] rd,
                         input logic rw, input logic mr, input logic fl, input logic mrdy);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        mem_ready   = mrdy;
    endtask

    task automatic chk_zero_slots(input string tag);
        chk({tag, " ex_rd"}, {14'd0, ex_rd}, 16'd0);
        chk({tag, " mem_rd"}, {14'd0, mem_rd}, 16'd0);
        chk({tag, " wb_rd"}, {14'd0, wb_rd}, 16'd0);
        chk({tag, " ex_rw"}, {15'd0, ex_regwrite}, 16'd0);
        chk({tag, " mem_rw"}, {15'd0, mem_regwrite}, 16'd0);
        chk({tag, " wb_rw"}, {15'd0, wb_regwrite}, 16'd0);
        chk({tag, " pend"}, {12'd0, pend_mask}, 16'd0);
    endtask

    initial begin
        // v rs rt urs urt rd rw mr fl mrdy | stall bubble | exrd exrw memrd memrw wbrd wbrw pend
        vecs[0]  = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd2,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0, 2'd2,1'b1,2'd0,1'b0,2'd0,1'b0,4'b0100};
        vecs[1]  = '{1'b1,2'd2,2'd0,1'b1,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1, 2'd0,1'b0,2'd2,1'b1,2'd0,1'b0,4'b0100};
        vecs[2]  = '{1'b1,2'd2,2'd0,1'b1,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd3,1'b1,2'd0,1'b0,2'd2,1'b1,4'b1100};
        vecs[3]  = '{1'b0,2'd3,2'd0,1'b1,1'b0,2'd1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd3,1'b1,2'd0,1'b0,4'b1000};
        vecs[4]  = '{1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd0,1'b0,2'd3,1'b1,4'b1000};
        vecs[5]  = '{1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd0,1'b0,2'd0,1'b0,4'b0000};
        vecs[6]  = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd1,1'b1,2'd0,1'b0,2'd0,1'b0,4'b0010};
        vecs[7]  = '{1'b1,2'd1,2'd1,1'b1,1'b1,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd0,1'b0,2'd1,1'b1,2'd0,1'b0,4'b0010};
        vecs[8]  = '{1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd0,1'b0,2'd1,1'b1,4'b0010};
        vecs[9]  = '{1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd0,1'b0,2'd0,1'b0,4'b0000};
        vecs[10] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0, 2'd3,1'b1,2'd0,1'b0,2'd0,1'b0,4'b1000};
        vecs[11] = '{1'b1,2'd0,2'd1,1'b1,1'b1,2'd2,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd2,1'b1,2'd3,1'b1,2'd0,1'b0,4'b1100};
        vecs[12] = '{1'b1,2'd3,2'd0,1'b1,1'b0,2'd0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd0,1'b1,2'd2,1'b1,2'd3,1'b1,4'b1101};
        vecs[13] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd3,1'b1,2'd0,1'b1,2'd2,1'b1,4'b1101};
        vecs[14] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 2'd3,1'b1,2'd0,1'b1,2'd2,1'b1,4'b1101};
        vecs[15] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 2'd3,1'b1,2'd0,1'b1,2'd2,1'b1,4'b1101};
        vecs[16] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 2'd3,1'b1,2'd0,1'b1,2'd2,1'b1,4'b1101};
        vecs[17] = '{1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd3,1'b1,2'd0,1'b1,4'b1001};
        vecs[18] = '{1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd0,1'b0,2'd3,1'b1,4'b1000};
        vecs[19] = '{1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd0,1'b0,2'd0,1'b0,4'b0000};
        vecs[20] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd3,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd0,1'b0,2'd0,1'b0,4'b0000};
        vecs[21] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd2,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0, 2'd2,1'b1,2'd0,1'b0,2'd0,1'b0,4'b0100};
        vecs[22] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0, 2'd0,1'b0,2'd0,1'b0,2'd0,1'b0,4'b0000};
        vecs[23] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd2,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0, 2'd2,1'b1,2'd0,1'b0,2'd0,1'b0,4'b0100};
        vecs[24] = '{1'b1,2'd2,2'd0,1'b1,1'b0,2'd1,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1, 2'd0,1'b0,2'd2,1'b1,2'd0,1'b0,4'b0100};
        vecs[25] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0, 2'd1,1'b1,2'd0,1'b0,2'd2,1'b1,4'b0110};
        vecs[26] = '{1'b0,2'd1,2'd0,1'b1,1'b0,2'd3,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1, 2'd0,1'b0,2'd1,1'b1,2'd0,1'b0,4'b0010};
        vecs[27] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0, 2'd0,1'b1,2'd0,1'b0,2'd1,1'b1,4'b0011};
        vecs[28] = '{1'b1,2'd0,2'd0,1'b0,1'b1,2'd2,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1, 2'd0,1'b0,2'd0,1'b1,2'd0,1'b0,4'b0001};
        vecs[29] = '{1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0, 2'd1,1'b1,2'd0,1'b0,2'd0,1'b1,4'b0011};
        vecs[30] = '{1'b1,2'd1,2'd1,1'b0,1'b0,2'd2,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0, 2'd2,1'b1,2'd1,1'b1,2'd0,1'b0,4'b0110};

        rst_n = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk_zero_slots("reset");
        chk("reset stall_id", {15'd0, stall_id}, 16'd0);
        chk("reset bubble_ex", {15'd0, bubble_ex}, 16'd1);
`ifdef HAZARD_SB_STATS_EN
        chk("reset stall_cycles", stall_cycles, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
                  vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].fl, vecs[i].mrdy);
            #1;
            chk($sformatf("v%0d stall_id", i), {15'd0, stall_id}, {15'd0, vecs[i].e_stall});
            chk($sformatf("v%0d bubble_ex", i), {15'd0, bubble_ex}, {15'd0, vecs[i].e_bubble});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_rd", i), {14'd0, ex_rd}, {14'd0, vecs[i].e_ex_rd});
            chk($sformatf("v%0d ex_rw", i), {15'd0, ex_regwrite}, {15'd0, vecs[i].e_ex_rw});
            chk($sformatf("v%0d mem_rd", i), {14'd0, mem_rd}, {14'd0, vecs[i].e_mem_rd});
            chk($sformatf("v%0d mem_rw", i), {15'd0, mem_regwrite}, {15'd0, vecs[i].e_mem_rw});
            chk($sformatf("v%0d wb_rd", i), {14'd0, wb_rd}, {14'd0, vecs[i].e_wb_rd});
            chk($sformatf("v%0d wb_rw", i), {15'd0, wb_regwrite}, {15'd0, vecs[i].e_wb_rw});
            chk($sformatf("v%0d pend", i), {12'd0, pend_mask}, {12'd0, vecs[i].e_pend});
        end

        // Fill all three slots: EX=R3, MEM=R2, WB=R1
        @(negedge clk);
        drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("full pend", {12'd0, pend_mask}, 16'h000E);
        chk("full wb_rd", {14'd0, wb_rd}, 16'd1);

        // Asynchronous reset between edges while frozen
        @(negedge clk);
        drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_slots("async rst");
        chk("async rst stall_id", {15'd0, stall_id}, 16'd1);
        chk("async rst bubble_ex", {15'd0, bubble_ex}, 16'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst across edge ex_rw", {15'd0, ex_regwrite}, 16'd0);
        chk("rst across edge pend", {12'd0, pend_mask}, 16'd0);
`ifdef HAZARD_SB_STATS_EN
        chk("rst stall_cycles", stall_cycles, 16'd0);
`endif

        // First edge after release sees an empty pipeline
        @(negedge clk);
        drive(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("post rst stall_id", {15'd0, stall_id}, 16'd0);
        @(posedge clk);
        #1;
        chk("post rst ex_rd", {14'd0, ex_rd}, 16'd2);
        chk("post rst mem_rw", {15'd0, mem_regwrite}, 16'd0);
        chk("post rst pend", {12'd0, pend_mask}, 16'h0004);

`ifdef HAZARD_SB_STATS_EN
        // Frozen pipeline with a load-use consumer: stall every edge until saturation
        @(negedge clk);
        drive(1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("stats count 5", stall_cycles, 16'd5);
        repeat (69995) @(posedge clk);
        #1;
        chk("stats saturate", stall_cycles, 16'hFFFF);
        chk("stats held ex_rd", {14'd0, ex_rd}, 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port id_valid, input, 1: ID stage holds a real instruction.
REQ-004 SHALL have ports id_rs and id_rt, input, 2 each: ID source register addresses.
REQ-005 SHALL have ports id_use_rs and id_use_rt, input, 1 each: the instruction actually reads that source.
REQ-006 SHALL have port id_rd, input, 2: ID destination register.
REQ-007 SHALL have ports id_regwrite and id_memread, input, 1 each: ID writes a register, and ID is a load.
REQ-008 SHALL have port flush, input, 1: squash the ID instruction (taken branch or jump).
REQ-009 SHALL have port mem_ready, input, 1: data memory done; 0 freezes the whole pipeline.
REQ-010 SHALL have port stall_id, output, 1: hold PC and IF/ID.
REQ-011 SHALL have port bubble_ex, output, 1: load NOP into ID/EX.
REQ-012 SHALL have ports ex_rd, mem_rd and wb_rd, output, 2 each: tracked destination per stage.
REQ-013 SHALL have ports ex_regwrite, mem_regwrite and wb_regwrite, output, 1 each: tracked write-enable per stage. The mem_* and wb_* pairs feed the forwarding unit.
REQ-014 SHALL have port pend_mask, output, 4: bit r set while any in-flight write targets register r.

Function
REQ-015 SHALL keep three shadow slots, EX, MEM and WB. Each slot holds {regwrite, rd, memread}.
REQ-016 SHALL define advance = mem_ready and issue = id_valid & ~stall_id & ~flush.
REQ-017 SHALL, on an edge with advance=1, shift WB<=MEM and MEM<=EX. EX<=ID fields if issue=1, else EX<=bubble (all fields 0).
REQ-018 SHALL, on an edge with advance=0, hold MEM and WB. EX is also held, except when flush=1, which clears EX to a bubble.
REQ-019 SHALL assert stall_id combinationally when either condition holds:
- load-use: id_valid & EX.regwrite & EX.memread & ((id_use_rs & id_rs==EX.rd) | (id_use_rt & id_rt==EX.rd));
- mem_ready=0.
REQ-020 SHALL never raise a load-use stall for a source whose matching producer is in MEM or WB (forwarding covers those).
REQ-021 SHALL drive bubble_ex = advance & ~issue, combinationally.
REQ-022 SHALL drive the ex_*, mem_* and wb_* outputs directly from slot registers, giving zero-cycle latency after the edge.
REQ-023 SHALL compute pend_mask[r] = OR over the three slots of (regwrite & rd==r).
REQ-024 SHALL give flush priority over a load-use stall: with flush=1 nothing issues, and stall_id follows REQ-019 unchanged.
REQ-025 SHALL ignore id_use_*, id_rd and similar ID fields when id_valid=0. No stall results, and only a bubble enters EX.

Reset
REQ-026 SHALL, while rst_n=0, clear all slots to bubble, irrespective of clk.
REQ-027 SHALL therefore drive all rd, regwrite and pend_mask outputs to 0 during reset. stall_id and bubble_ex SHALL follow their equations from the cleared state.
REQ-028 SHALL treat reset mid-stall as discarding all in-flight instructions. The first edge after release behaves as an empty pipeline.

Configuration
REQ-029 SHALL, with HAZARD_SB_STATS_EN defined, add output stall_cycles (16 bits, reset 0).
- Increments on each edge where id_valid & stall_id.
- Saturates at 16'hFFFF.
REQ-030 SHALL, without HAZARD_SB_STATS_EN, omit the stall_cycles port and counter entirely, with otherwise identical behaviour.

Verification
REQ-031 Load-use: cycle 0 issue id_rd=2, memread=1; cycle 1 id_rs=2, use_rs=1 -> stall_id=1 and bubble_ex=1 for exactly one cycle. Next cycle issues, with mem_rd=2 and mem_regwrite=1.
REQ-032 ALU producer: issue id_rd=1 (regwrite=1, no memread), then a consumer of R1 -> no stall. Following cycles: mem_rd=1 with mem_regwrite=1, then wb_rd=1 with wb_regwrite=1; pend_mask=4'b0010 across the three cycles, then 0.
REQ-033 Memory wait: mem_ready=0 for 3 cycles with slots EX=R3, MEM=R0 -> stall_id=1, all slot outputs held. On mem_ready=1 the shift resumes.
REQ-034 Flush: flush=1 with id_rd=3 and regwrite=1 -> EX becomes bubble (ex_regwrite=0), bubble_ex=1, pend_mask[3]=0.
REQ-035 Reset mid-operation: assert rst_n=0 asynchronously between edges with all slots valid -> all outputs 0 immediately. With HAZARD_SB_STATS_EN, stall_cycles=0.
REQ-036 Stats saturation, with the macro defined: hold a load-use stall for 70000 cycles -> stall_cycles=16'hFFFF, with no wrap.
